// File: rtl/panel_sequencer_core_if.sv
// Host configuration port of the panel sequencer: random-access LUT write/read.
interface panel_sequencer_core_if #(
  parameter int ADDR_W  = 8,
  parameter int ENTRY_W = 30
);
  logic               cfg_wen_i;
  logic               cfg_ren_i;
  logic [ADDR_W-1:0]  cfg_addr_i;
  logic [ENTRY_W-1:0] cfg_wdata_i;
  logic [ENTRY_W-1:0] cfg_rdata_o;
  logic               cfg_rvalid_o;

  modport master (
    output cfg_wen_i, cfg_ren_i, cfg_addr_i, cfg_wdata_i,
    input  cfg_rdata_o, cfg_rvalid_o
  );

  modport slave (
    input  cfg_wen_i, cfg_ren_i, cfg_addr_i, cfg_wdata_i,
    output cfg_rdata_o, cfg_rvalid_o
  );
endinterface

// File: rtl/panel_sequencer_core.sv
// LUT-driven panel timing sequencer: steps through host-programmed entries and drives one-hot phase enables.
// Optional macro SEQ_ERR_CHK_EN: abort with sticky err_o on reserved state code 0 or an address wrap without eof.
module panel_sequencer_core #(
  parameter int ADDR_W  = 8,
  parameter int STATE_W = 3,
  parameter int RPT_W   = 8,
  parameter int LEN_W   = 16
) (
  input  logic                  clk,
  input  logic                  reset_i,
  panel_sequencer_core_if.slave cfg,
  input  logic                  start_i,
  input  logic                  stop_i,
  input  logic [RPT_W-1:0]      seq_loops_i,
  input  logic                  ext_done_i,
  output logic                  busy_o,
  output logic [2**STATE_W-1:0] phase_en_o,
  output logic [ADDR_W-1:0]     cur_addr_o,
  output logic [LEN_W-1:0]      remain_len_o,
  output logic [RPT_W-1:0]      remain_rpt_o,
  output logic                  sof_o,
  output logic                  eof_o,
  output logic                  seq_done_o,
  output logic                  err_o
);
  localparam int ENTRY_W = STATE_W + RPT_W + LEN_W + 3;
  localparam int DEPTH   = 2**ADDR_W;

  typedef enum logic [2:0] {S_CFG, S_FETCH, S_RUN, S_WAIT, S_DONE} state_e;

  state_e              state_q, state_d;
  logic [ENTRY_W-1:0]  mem_q [DEPTH];
  logic [ENTRY_W-1:0]  ent_q, ent_d, cfg_rdata_q, cfg_rdata_d;
  logic                rvalid_q, rvalid_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [LEN_W-1:0]    len_q, len_d, len_ld_q, len_ld_d;
  logic [RPT_W-1:0]    rpt_q, rpt_d, loop_q, loop_d;
  logic [STATE_W-1:0]  phase_q, phase_d;
  logic                wait_q, wait_d, eof_q, eof_d, stop_q, stop_d, sof_q, sof_d;
  logic                advance, stop_any;
`ifdef SEQ_ERR_CHK_EN
  logic                err_q, err_d;
`endif

  logic [STATE_W-1:0]  ent_state;
  logic [RPT_W-1:0]    ent_rpt;
  logic [LEN_W-1:0]    ent_len;
  logic                ent_wait, ent_eof, ent_sof;

  assign ent_state = ent_q[STATE_W-1:0];
  assign ent_rpt   = ent_q[STATE_W +: RPT_W];
  assign ent_len   = ent_q[STATE_W+RPT_W +: LEN_W];
  assign ent_wait  = ent_q[ENTRY_W-3];
  assign ent_eof   = ent_q[ENTRY_W-2];
  assign ent_sof   = ent_q[ENTRY_W-1];

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    len_d       = len_q;
    len_ld_d    = len_ld_q;
    rpt_d       = rpt_q;
    loop_d      = loop_q;
    phase_d     = phase_q;
    wait_d      = wait_q;
    eof_d       = eof_q;
    stop_d      = stop_q;
    sof_d       = 1'b0;
    rvalid_d    = 1'b0;
    cfg_rdata_d = cfg_rdata_q;
    advance     = 1'b0;
    stop_any    = stop_q | stop_i;
`ifdef SEQ_ERR_CHK_EN
    err_d       = err_q;
`endif
    if (state_q != S_CFG && stop_i) stop_d = 1'b1;

    case (state_q)
      S_CFG: begin
        stop_d = 1'b0;
        if (!cfg.cfg_wen_i && cfg.cfg_ren_i) begin
          rvalid_d    = 1'b1;
          cfg_rdata_d = mem_q[cfg.cfg_addr_i];
        end
        if (start_i) begin
          state_d = S_FETCH;
          addr_d  = '0;
          loop_d  = seq_loops_i;
`ifdef SEQ_ERR_CHK_EN
          err_d   = 1'b0;
`endif
        end
      end
      S_FETCH: begin
        state_d  = S_RUN;
        phase_d  = ent_state;
        len_d    = (ent_len == '0) ? LEN_W'(1) : ent_len;
        len_ld_d = (ent_len == '0) ? LEN_W'(1) : ent_len;
        rpt_d    = (ent_rpt == '0) ? RPT_W'(1) : ent_rpt;
        wait_d   = ent_wait;
        eof_d    = ent_eof;
        sof_d    = ent_sof;
`ifdef SEQ_ERR_CHK_EN
        if (ent_state == '0) begin
          state_d = S_DONE;
          sof_d   = 1'b0;
          err_d   = 1'b1;
        end
`endif
      end
      S_RUN: begin
        // Repeats reload the timer without leaving RUN, so the phase enable never drops between them.
        if (len_q > LEN_W'(1)) begin
          len_d = len_q - LEN_W'(1);
        end else if (rpt_q > RPT_W'(1)) begin
          rpt_d = rpt_q - RPT_W'(1);
          len_d = len_ld_q;
        end else begin
          len_d = '0;
          if (wait_q && !ext_done_i) state_d = S_WAIT;
          else                       advance = 1'b1;
        end
      end
      S_WAIT: if (ext_done_i) advance = 1'b1;
      S_DONE: state_d = S_CFG;
      default: state_d = S_CFG;
    endcase

    if (advance) begin
      if (eof_q) begin
        if (loop_q == RPT_W'(1) || stop_any) begin
          state_d = S_DONE;
        end else begin
          if (loop_q != '0) loop_d = loop_q - RPT_W'(1);
          addr_d  = '0;
          state_d = S_FETCH;
        end
      end else if (stop_any) begin
        state_d = S_DONE;
`ifdef SEQ_ERR_CHK_EN
      end else if (addr_q == '1) begin
        state_d = S_DONE;
        err_d   = 1'b1;
`endif
      end else begin
        addr_d  = addr_q + ADDR_W'(1);
        state_d = S_FETCH;
      end
    end

    // Read address follows addr_d so the entry is registered by the end of the FETCH cycle.
    ent_d = mem_q[addr_d];
  end

  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= S_CFG;
      addr_q      <= '0;
      len_q       <= '0;
      len_ld_q    <= '0;
      rpt_q       <= '0;
      loop_q      <= '0;
      phase_q     <= '0;
      wait_q      <= 1'b0;
      eof_q       <= 1'b0;
      stop_q      <= 1'b0;
      sof_q       <= 1'b0;
      rvalid_q    <= 1'b0;
      cfg_rdata_q <= '0;
`ifdef SEQ_ERR_CHK_EN
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      len_ld_q    <= len_ld_d;
      rpt_q       <= rpt_d;
      loop_q      <= loop_d;
      phase_q     <= phase_d;
      wait_q      <= wait_d;
      eof_q       <= eof_d;
      stop_q      <= stop_d;
      sof_q       <= sof_d;
      rvalid_q    <= rvalid_d;
      cfg_rdata_q <= cfg_rdata_d;
`ifdef SEQ_ERR_CHK_EN
      err_q       <= err_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == S_CFG && cfg.cfg_wen_i) mem_q[cfg.cfg_addr_i] <= cfg.cfg_wdata_i;
    ent_q <= ent_d;
  end

  always_comb begin
    phase_en_o = '0;
    if (state_q == S_RUN || state_q == S_WAIT) phase_en_o[phase_q] = 1'b1;
  end

  assign busy_o           = (state_q != S_CFG);
  assign cur_addr_o       = addr_q;
  assign remain_len_o     = len_q;
  assign remain_rpt_o     = rpt_q;
  assign sof_o            = sof_q;
  assign eof_o            = advance & eof_q;
  assign seq_done_o       = (state_q == S_DONE);
  assign cfg.cfg_rdata_o  = cfg_rdata_q;
  assign cfg.cfg_rvalid_o = rvalid_q;
`ifdef SEQ_ERR_CHK_EN
  assign err_o            = err_q;
`else
  assign err_o            = 1'b0;
`endif
endmodule

// File: tb/tb_panel_sequencer_core.sv
// Randomized bench for panel_sequencer_core: a table-level reference model builds the expected
// per-cycle phase/flag trace of each sequence run, and directed runs cover the listed scenarios.
module tb_panel_sequencer_core;
  localparam int ADDR_W = 8, STATE_W = 3, RPT_W = 8, LEN_W = 16;
  localparam int ENTRY_W = STATE_W + RPT_W + LEN_W + 3;
  localparam int PH_W = 2**STATE_W;
  localparam int NCYC = 4096;

  logic                clk = 1'b0;
  logic                reset_i;
  logic                start_i, stop_i, ext_done_i;
  logic [RPT_W-1:0]    seq_loops_i;
  logic                busy_o, sof_o, eof_o, seq_done_o, err_o;
  logic [PH_W-1:0]     phase_en_o;
  logic [ADDR_W-1:0]   cur_addr_o;
  logic [LEN_W-1:0]    remain_len_o;
  logic [RPT_W-1:0]    remain_rpt_o;

  panel_sequencer_core_if #(.ADDR_W(ADDR_W), .ENTRY_W(ENTRY_W)) cfg_if ();

  panel_sequencer_core #(.ADDR_W(ADDR_W), .STATE_W(STATE_W), .RPT_W(RPT_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .reset_i(reset_i), .cfg(cfg_if), .start_i(start_i), .stop_i(stop_i),
    .seq_loops_i(seq_loops_i), .ext_done_i(ext_done_i), .busy_o(busy_o), .phase_en_o(phase_en_o),
    .cur_addr_o(cur_addr_o), .remain_len_o(remain_len_o), .remain_rpt_o(remain_rpt_o),
    .sof_o(sof_o), .eof_o(eof_o), .seq_done_o(seq_done_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  int t_st[256], t_len[256], t_rpt[256], t_wt[256], t_eof[256], t_sof[256];
  logic [ENTRY_W-1:0] shadow[256];
  bit ext[NCYC];
  int exp_ph[$], exp_fl[$], exp_ad[$];
  int cnt_ph[PH_W];
  int cnt_eof, cnt_done;
  int obs_ad[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [ENTRY_W-1:0] pack(input int i);
    return {t_sof[i][0], t_eof[i][0], t_wt[i][0], t_len[i][15:0], t_rpt[i][7:0], t_st[i][2:0]};
  endfunction

  task automatic set_e(input int i, input int st, input int len, input int rpt,
                       input int wt, input int eof, input int sof);
    t_st[i] = st; t_len[i] = len; t_rpt[i] = rpt; t_wt[i] = wt; t_eof[i] = eof; t_sof[i] = sof;
  endtask

  task automatic wr(input int a, input logic [ENTRY_W-1:0] d);
    cfg_if.cfg_wen_i = 1'b1; cfg_if.cfg_addr_i = ADDR_W'(a); cfg_if.cfg_wdata_i = d;
    @(posedge clk); #1;
    cfg_if.cfg_wen_i = 1'b0;
  endtask

  task automatic rd_chk(input int a, input logic [ENTRY_W-1:0] e);
    cfg_if.cfg_ren_i = 1'b1; cfg_if.cfg_addr_i = ADDR_W'(a);
    @(posedge clk); #1;
    cfg_if.cfg_ren_i = 1'b0;
    @(negedge clk);
    chk("rd_rvalid", cfg_if.cfg_rvalid_o, 1);
    chk("rd_data", cfg_if.cfg_rdata_o, e);
    @(posedge clk); #1;
  endtask

  task automatic load_tbl(input int n);
    for (int i = 0; i < n; i++) begin
      shadow[i] = pack(i);
      wr(i, shadow[i]);
    end
  endtask

  task automatic ext_fill(input int high_from, input bit rnd);
    for (int t = 0; t < NCYC; t++)
      ext[t] = (t >= NCYC - 100) ? 1'b1 : (rnd ? ($urandom_range(0, 2) == 0) : (t >= high_from));
  endtask

  // Expected trace, t=0 is the first cycle after start: 1 fetch gap per entry, len*rpt phase
  // cycles, extended until ext_done for wait entries; then one DONE cycle and one idle cycle.
  // flags = {busy, sof, eof, seq_done, err}
  task automatic build_expect(input int loops, input int stop_at);
    int t, addr, lp, last_end, first;
    bit fin, err, stop_hit;
    exp_ph.delete(); exp_fl.delete(); exp_ad.delete();
    t = 0; addr = 0; lp = loops; fin = 0; err = 0;
    while (!fin && t < NCYC - 200) begin
      exp_ph.push_back(0); exp_fl.push_back(16); exp_ad.push_back(addr); t++;
`ifdef SEQ_ERR_CHK_EN
      if (t_st[addr] == 0) begin err = 1; break; end
`endif
      first = t;
      last_end = t + (t_len[addr] == 0 ? 1 : t_len[addr]) * (t_rpt[addr] == 0 ? 1 : t_rpt[addr]) - 1;
      if (t_wt[addr] != 0) while (!ext[last_end]) last_end++;
      for (int k = first; k <= last_end; k++) begin
        exp_ph.push_back(1 << t_st[addr]);
        exp_fl.push_back(16 | ((k == first && t_sof[addr] != 0) ? 8 : 0)
                            | ((k == last_end && t_eof[addr] != 0) ? 4 : 0));
        exp_ad.push_back(addr);
      end
      t = last_end + 1;
      stop_hit = (stop_at >= 0 && stop_at <= last_end);
      if (t_eof[addr] != 0) begin
        if (lp == 1 || stop_hit) fin = 1;
        else begin
          if (lp != 0) lp--;
          addr = 0;
        end
      end else if (stop_hit) fin = 1;
      else if (addr == 255) begin
`ifdef SEQ_ERR_CHK_EN
        err = 1; fin = 1;
`else
        addr = 0;
`endif
      end else addr++;
    end
    exp_ph.push_back(0); exp_fl.push_back(16 | 2 | int'(err)); exp_ad.push_back(-1);
    exp_ph.push_back(0); exp_fl.push_back(int'(err));          exp_ad.push_back(-1);
  endtask

  task automatic run_seq(input int loops, input int stop_at);
    logic [PH_W-1:0] prev_ph;
    build_expect(loops, stop_at);
    for (int b = 0; b < PH_W; b++) cnt_ph[b] = 0;
    cnt_eof = 0; cnt_done = 0; obs_ad.delete(); prev_ph = '0;
    seq_loops_i = RPT_W'(loops); start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    for (int t = 0; t < exp_ph.size(); t++) begin
      ext_done_i = ext[t];
      stop_i = (t == stop_at);
      // Strobes and restarts while busy must all be ignored.
      if (exp_fl[t][4]) begin
        start_i = 1'($urandom_range(0, 1));
        cfg_if.cfg_wen_i = 1'($urandom_range(0, 1));
        cfg_if.cfg_ren_i = 1'($urandom_range(0, 1));
        cfg_if.cfg_addr_i = ADDR_W'($urandom);
        cfg_if.cfg_wdata_i = ENTRY_W'($urandom);
      end else begin
        start_i = 1'b0; cfg_if.cfg_wen_i = 1'b0; cfg_if.cfg_ren_i = 1'b0;
      end
      @(negedge clk);
      chk("phase_en", phase_en_o, exp_ph[t]);
      chk("flags", {busy_o, sof_o, eof_o, seq_done_o, err_o}, exp_fl[t]);
      chk("rvalid_busy", cfg_if.cfg_rvalid_o, 0);
      if (exp_ad[t] >= 0) chk("cur_addr", cur_addr_o, exp_ad[t]);
      for (int b = 0; b < PH_W; b++) if (phase_en_o[b]) cnt_ph[b]++;
      if (eof_o) cnt_eof++;
      if (seq_done_o) cnt_done++;
      if (phase_en_o != '0 && prev_ph == '0) obs_ad.push_back(int'(cur_addr_o));
      prev_ph = phase_en_o;
      @(posedge clk); #1;
    end
    start_i = 1'b0; stop_i = 1'b0; ext_done_i = 1'b0;
    cfg_if.cfg_wen_i = 1'b0; cfg_if.cfg_ren_i = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset_i = 1'b1; start_i = 1'b0; stop_i = 1'b0; ext_done_i = 1'b0; seq_loops_i = '0;
    cfg_if.cfg_wen_i = 1'b0; cfg_if.cfg_ren_i = 1'b0; cfg_if.cfg_addr_i = '0; cfg_if.cfg_wdata_i = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_outs", {busy_o, sof_o, eof_o, seq_done_o, err_o, cfg_if.cfg_rvalid_o}, 0);
    chk("rst_phase", phase_en_o, 0);
    chk("rst_addr", cur_addr_o, 0);
    chk("rst_cnt", {remain_len_o, remain_rpt_o}, 0);
    chk("rst_rdata", cfg_if.cfg_rdata_o, 0);
    @(posedge clk); #1;
    reset_i = 1'b0;

    // Config port: write/read latency, pulse width, write wins over read.
    wr(5, ENTRY_W'('h2A));
    cfg_if.cfg_ren_i = 1'b1; cfg_if.cfg_addr_i = 8'd5;
    @(negedge clk);
    chk("rd_same_cycle", cfg_if.cfg_rvalid_o, 0);
    @(posedge clk); #1;
    cfg_if.cfg_ren_i = 1'b0;
    @(negedge clk);
    chk("rd_valid", cfg_if.cfg_rvalid_o, 1);
    chk("rd_2a", cfg_if.cfg_rdata_o, 'h2A);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rd_pulse", cfg_if.cfg_rvalid_o, 0);
    @(posedge clk); #1;
    cfg_if.cfg_wen_i = 1'b1; cfg_if.cfg_ren_i = 1'b1; cfg_if.cfg_addr_i = 8'd6; cfg_if.cfg_wdata_i = ENTRY_W'('h155);
    @(posedge clk); #1;
    cfg_if.cfg_wen_i = 1'b0; cfg_if.cfg_ren_i = 1'b0;
    @(negedge clk);
    chk("wr_wins", cfg_if.cfg_rvalid_o, 0);
    @(posedge clk); #1;
    rd_chk(6, ENTRY_W'('h155));

    // Two-entry table, single loop.
    set_e(0, 2, 4, 1, 0, 0, 1);
    set_e(1, 6, 3, 2, 0, 1, 0);
    load_tbl(2);
    ext_fill(0, 0);
    run_seq(1, -1);
    chk("ph2_cycles", cnt_ph[2], 4);
    chk("ph6_cycles", cnt_ph[6], 6);
    chk("done_pulses", cnt_done, 1);

    // Wait on external handshake, raised in the fifth phase cycle.
    set_e(0, 3, 2, 1, 1, 1, 0);
    load_tbl(1);
    ext_fill(5, 0);
    run_seq(1, -1);
    chk("wait_ph3_cycles", cnt_ph[3], 5);
    chk("wait_eof", cnt_eof, 1);

    // Stop while idle is ignored, then three loops over two entries.
    set_e(0, 1, 1, 1, 0, 0, 0);
    set_e(1, 4, 2, 1, 0, 1, 1);
    load_tbl(2);
    ext_fill(0, 0);
    stop_i = 1'b1;
    @(posedge clk); #1;
    stop_i = 1'b0;
    run_seq(3, -1);
    chk("loop_eofs", cnt_eof, 3);
    chk("loop_done", cnt_done, 1);
    chk("loop_entries", obs_ad.size(), 6);
    for (int i = 0; i < obs_ad.size() && i < 6; i++) chk("loop_addr", obs_ad[i], i % 2);

    // Endless loop with a stop during entry 0.
    set_e(0, 2, 6, 1, 0, 0, 0);
    set_e(1, 5, 2, 1, 0, 1, 0);
    load_tbl(2);
    run_seq(0, 3);
    chk("stop_ph2", cnt_ph[2], 6);
    chk("stop_ph5", cnt_ph[5], 0);
    chk("stop_done", cnt_done, 1);

`ifdef SEQ_ERR_CHK_EN
    set_e(0, 1, 1, 1, 0, 0, 0);
    set_e(1, 0, 1, 1, 0, 1, 0);
    load_tbl(2);
    run_seq(1, -1);
    chk("err_set", err_o, 1);
    set_e(1, 3, 1, 1, 0, 1, 0);
    load_tbl(2);
    run_seq(1, -1);
    chk("err_cleared", err_o, 0);
`endif

    // Randomized tables against the model; busy-time strobes must not alter the LUT.
    for (int it = 0; it < 6; it++) begin
      n = $urandom_range(2, 4);
      for (int i = 0; i < n; i++)
        set_e(i, $urandom_range(1, 7), $urandom_range(0, 4), $urandom_range(0, 3),
              $urandom_range(0, 1), (i == n - 1) ? 1 : 0, $urandom_range(0, 1));
      load_tbl(n);
      ext_fill(0, 1);
      if (it % 2 == 1) run_seq(0, $urandom_range(0, 20));
      else             run_seq($urandom_range(1, 3), -1);
      for (int i = 0; i < n; i++) rd_chk(i, shadow[i]);
    end

    // Full table without eof: walks through address wrap.
    for (int i = 0; i < 256; i++) set_e(i, 1 + (i % 7), 1, 1, 0, 0, 0);
    load_tbl(256);
    ext_fill(0, 0);
    run_seq(0, 517);

    // Asynchronous reset mid-sequence keeps the LUT.
    set_e(0, 2, 4, 1, 0, 0, 1);
    set_e(1, 6, 3, 2, 0, 1, 0);
    load_tbl(2);
    seq_loops_i = 8'd1; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset_i = 1'b1;
    #1;
    chk("abort_busy", {busy_o, seq_done_o, err_o}, 0);
    chk("abort_phase", phase_en_o, 0);
    chk("abort_addr", cur_addr_o, 0);
    @(posedge clk); #1;
    reset_i = 1'b0;
    rd_chk(0, shadow[0]);
    rd_chk(1, shadow[1]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
